id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
Pipeline control unit sitting beside the decoder and the ID_EX register in the 5-stage RISC-V core.
- Keeps a shadow tracker of the destination registers in flight in EX, MEM and WB.
- Detects load-use hazards and stalls PC and IF/ID while inserting a bubble into ID_EX.
- Flushes wrong-path instructions when EX resolves a taken branch or jump.
- Emits forwarding selects, registered so they are aligned with the instruction in EX.

Parameters:
REG_W, 5, register index width
LOAD_LAT, 1, bubbles required after a load before a dependent instruction (legal values 1 or 2)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a valid instruction
id_opcode  in  7  opcode of the ID instruction, from decoder
id_rs1  in  REG_W  rs1 field from decoder
id_rs2  in  REG_W  rs2 field from decoder
id_rd  in  REG_W  rd field from decoder
ex_redirect  in  1  branch/jump taken in EX this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID_EX instead of the ID instruction
issue  out  1  ID instruction enters EX at this edge
fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Opcode classes (combinational from id_opcode):
  - writes_rd: R 0110011, I 0010011, load 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - uses_rs1: all classes except LUI, AUIPC, JAL.
  - uses_rs2: R, store 0100011, branch 1100011.
  - Unknown opcode: no writes, no reads.
  - rd==0 is never treated as a write.
- Tracker: three entries (EX, MEM, WB), each {valid, rd, is_load, wr}.
  - Every edge: WB<=MEM, MEM<=EX, EX<=issue ? ID entry : empty.
- Load-use stall (combinational), asserted when id_valid and the ID instruction reads a register that matches a valid, wr, is_load entry in EX.
  - With LOAD_LAT=2, an is_load match in MEM also stalls.
  - Stall drives pc_stall=1, ifid_stall=1, idex_bubble=1, issue=0.
- Redirect: ex_redirect=1 drives ifid_flush=1, idex_bubble=1, issue=0, pc_stall=0, ifid_stall=0.
  - Redirect beats a simultaneous load-use stall; stall_cnt does not increment in that case.
- issue = id_valid & !stall & !ex_redirect. When !id_valid and no redirect, idex_bubble=1.
- Forwarding: computed in ID against EX and MEM entries, registered into fwd_a/fwd_b on the issue edge.
  - Match on the EX entry gives 01. Match on the MEM entry gives 10. The EX entry (younger) wins.
  - An unused source, x0, or a non-issue edge registers 00.
- stall_cnt: +1 on each edge where a non-redirected stall was asserted. Saturates at all-ones.
- Reset low: tracker cleared, fwd_a/fwd_b=00, stall_cnt=0, all combinational outputs 0. Applies immediately and mid-stall.
  - First edge after release behaves as from an empty pipe.

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR) and the FWD_RF/FWD_EXMEM/FWD_MEMWB encodings.
- One sub-module, hz_opclass: combinational opcode to {writes_rd, uses_rs1, uses_rs2, is_load}.

Test Plan:
- addi x2,x0,5 (0x00500113), then addi x3,x2,10 (0x00A10193) back-to-back -> no stall; fwd_a=01, fwd_b=00 on the cycle x3 is in EX.
- lw x2,0(x0) (0x00002103), then 0x00A10193 -> exactly 1 cycle of pc_stall/ifid_stall/idex_bubble=1; then issue with fwd_a=10; stall_cnt=1. With LOAD_LAT=2: 2 stall cycles, stall_cnt=2.
- 0x00500113, then sw x2,4(x0) (0x00202223) -> fwd_b=01, fwd_a=00.
- addi x0,x0,0 (0x00000013), then addi x3,x0,0 (0x00000193) -> no stall; fwd_a=00.
- lw x2 in EX, dependent in ID, ex_redirect=1 the same cycle -> ifid_flush=1, pc_stall=0, stall_cnt unchanged, EX entry empty next cycle.
- Assert reset low during the load-use stall cycle -> all outputs 0 at once; after release, 0x00A10193 issues with fwd_a=00.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared RISC-V decode constants for the ID-stage hazard controller:
// base opcodes, forwarding-select encodings and the opcode class record.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
    logic is_load;
  } opclass_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decoder/pipeline-register side of the hazard controller: ID fields and
// redirect in, stall/flush/issue/forwarding controls out.
interface id_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             ex_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             issue;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, issue,
           fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, issue,
           fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl_hz_opclass.sv
// Opcode classifier: which register fields an instruction reads/writes and
// whether it is a load. Unknown opcodes neither read nor write.
module hz_opclass
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R: begin
        cls.writes_rd = 1'b1;
        cls.uses_rs1  = 1'b1;
        cls.uses_rs2  = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        cls.writes_rd = 1'b1;
        cls.uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        cls.writes_rd = 1'b1;
        cls.uses_rs1  = 1'b1;
        cls.is_load   = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        cls.writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        cls.uses_rs1  = 1'b1;
        cls.uses_rs2  = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: tracks destinations in EX/MEM/WB, stalls on
// load-use, flushes on EX redirect and registers EX-aligned forwarding selects.
module id_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  id_hazard_ctrl_if.slave  hz
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic             wr;
  } trk_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  trk_t             trk_q [3];
  trk_t             id_ent;
  opclass_t         cls;
  logic             rs1_use, rs2_use;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             load_stall, stall, issue_c;
  logic [1:0]       sel_a, sel_b;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;

  hz_opclass u_opclass (
    .opcode (hz.id_opcode),
    .cls    (cls)
  );

  function automatic logic hit(trk_t e, logic use_src, logic [REG_W-1:0] rs);
    return use_src && e.valid && e.wr && (e.rd == rs);
  endfunction

  // x0 is neither a real source nor a real destination for hazard purposes.
  assign rs1_use = cls.uses_rs1 && (hz.id_rs1 != '0);
  assign rs2_use = cls.uses_rs2 && (hz.id_rs2 != '0);

  assign id_ent.valid   = 1'b1;
  assign id_ent.rd      = hz.id_rd;
  assign id_ent.is_load = cls.is_load;
  assign id_ent.wr      = cls.writes_rd && (hz.id_rd != '0);

  assign ex_hit_a  = hit(trk_q[EX],  rs1_use, hz.id_rs1);
  assign ex_hit_b  = hit(trk_q[EX],  rs2_use, hz.id_rs2);
  assign mem_hit_a = hit(trk_q[MEM], rs1_use, hz.id_rs1);
  assign mem_hit_b = hit(trk_q[MEM], rs2_use, hz.id_rs2);

  assign load_stall = ((ex_hit_a || ex_hit_b) && trk_q[EX].is_load) ||
                      ((LOAD_LAT == 2) && (mem_hit_a || mem_hit_b) && trk_q[MEM].is_load);
  assign stall      = hz.id_valid && load_stall;

  // Every control output is forced low while reset is held, including mid-stall.
  assign issue_c        = reset && hz.id_valid && !stall && !hz.ex_redirect;
  assign hz.issue       = issue_c;
  assign hz.idex_bubble = reset && !issue_c;
  assign hz.pc_stall    = reset && stall && !hz.ex_redirect;
  assign hz.ifid_stall  = reset && stall && !hz.ex_redirect;
  assign hz.ifid_flush  = reset && hz.ex_redirect;

  // The EX entry is the younger producer, so it takes priority over MEM.
  assign sel_a = ex_hit_a ? FWD_EXMEM : (mem_hit_a ? FWD_MEMWB : FWD_RF);
  assign sel_b = ex_hit_b ? FWD_EXMEM : (mem_hit_b ? FWD_MEMWB : FWD_RF);

  assign hz.fwd_a     = fwd_a_q;
  assign hz.fwd_b     = fwd_b_q;
  assign hz.stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) trk_q[i] <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      trk_q[WB]  <= trk_q[MEM];
      trk_q[MEM] <= trk_q[EX];
      trk_q[EX]  <= issue_c ? id_ent : '0;
      fwd_a_q    <= issue_c ? sel_a : FWD_RF;
      fwd_b_q    <= issue_c ? sel_b : FWD_RF;
      if (hz.pc_stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: vector table with a scoreboard for
// the registered outputs, plus sequences for reset, LOAD_LAT=2 and saturation.
module tb_id_hazard_ctrl;

  localparam logic [31:0] ADDI_X2    = 32'h00500113;
  localparam logic [31:0] ADDI_X3_X2 = 32'h00A10193;
  localparam logic [31:0] LW_X2      = 32'h00002103;
  localparam logic [31:0] SW_X2      = 32'h00202223;
  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ADDI_X3_X0 = 32'h00000193;
  localparam logic [31:0] LUI_X5     = 32'h000102B7;
  localparam logic [31:0] UNK_OP     = 32'h00010000;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        redir;
    logic        exp_stall;
    logic        exp_flush;
    logic        exp_bubble;
    logic        exp_issue;
    logic [1:0]  exp_fa;
    logic [1:0]  exp_fb;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } post_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  vec_t  vecs[$];
  post_t sb[$];

  id_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz1 ();
  id_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz2 ();
  id_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  hz3 ();

  id_hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(hz1));
  id_hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .hz(hz2));
  id_hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(2))  dut3 (.clk(clk), .reset(reset), .hz(hz3));

  assign hz2.id_valid    = hz1.id_valid;
  assign hz2.id_opcode   = hz1.id_opcode;
  assign hz2.id_rs1      = hz1.id_rs1;
  assign hz2.id_rs2      = hz1.id_rs2;
  assign hz2.id_rd       = hz1.id_rd;
  assign hz2.ex_redirect = hz1.ex_redirect;
  assign hz3.id_valid    = hz1.id_valid;
  assign hz3.id_opcode   = hz1.id_opcode;
  assign hz3.id_rs1      = hz1.id_rs1;
  assign hz3.id_rs2      = hz1.id_rs2;
  assign hz3.id_rd       = hz1.id_rd;
  assign hz3.ex_redirect = hz1.ex_redirect;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic valid, logic [31:0] instr, logic redir);
    hz1.id_valid    = valid;
    hz1.id_opcode   = instr[6:0];
    hz1.id_rd       = instr[11:7];
    hz1.id_rs1      = instr[19:15];
    hz1.id_rs2      = instr[24:20];
    hz1.ex_redirect = redir;
  endtask

  task automatic add_vec(logic valid, logic [31:0] instr, logic redir, logic st, logic fl,
                         logic bu, logic is, logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
    vec_t v;
    v.valid = valid; v.instr = instr; v.redir = redir;
    v.exp_stall = st; v.exp_flush = fl; v.exp_bubble = bu; v.exp_issue = is;
    v.exp_fa = fa; v.exp_fb = fb; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic add_issue(logic [31:0] instr, logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
    add_vec(1'b1, instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fa, fb, cnt);
  endtask

  task automatic add_idle(logic [15:0] cnt);
    add_vec(1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, cnt);
  endtask

  task automatic add_stall(logic [31:0] instr, logic [15:0] cnt);
    add_vec(1'b1, instr, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, cnt);
  endtask

  task automatic add_redir(logic valid, logic [31:0] instr, logic [15:0] cnt);
    add_vec(valid, instr, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, cnt);
  endtask

  // Combinational controls are checked before the edge; the registered
  // selects and counter are queued and compared just after it.
  task automatic apply_stimulus(vec_t v, int idx);
    post_t p;
    post_t got;
    @(negedge clk);
    drive(v.valid, v.instr, v.redir);
    #1;
    check_output($sformatf("v%0d_pc_stall", idx),    32'(hz1.pc_stall),    32'(v.exp_stall));
    check_output($sformatf("v%0d_ifid_stall", idx),  32'(hz1.ifid_stall),  32'(v.exp_stall));
    check_output($sformatf("v%0d_ifid_flush", idx),  32'(hz1.ifid_flush),  32'(v.exp_flush));
    check_output($sformatf("v%0d_idex_bubble", idx), 32'(hz1.idex_bubble), 32'(v.exp_bubble));
    check_output($sformatf("v%0d_issue", idx),       32'(hz1.issue),       32'(v.exp_issue));
    p.idx = idx; p.fa = v.exp_fa; p.fb = v.exp_fb; p.cnt = v.exp_cnt;
    sb.push_back(p);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_output($sformatf("v%0d_fwd_a", got.idx),     32'(hz1.fwd_a),     32'(got.fa));
    check_output($sformatf("v%0d_fwd_b", got.idx),     32'(hz1.fwd_b),     32'(got.fb));
    check_output($sformatf("v%0d_stall_cnt", got.idx), 32'(hz1.stall_cnt), 32'(got.cnt));
  endtask

  task automatic check_all_zero(string tag);
    check_output({tag, "_pc_stall"},    32'(hz1.pc_stall),    32'd0);
    check_output({tag, "_ifid_stall"},  32'(hz1.ifid_stall),  32'd0);
    check_output({tag, "_ifid_flush"},  32'(hz1.ifid_flush),  32'd0);
    check_output({tag, "_idex_bubble"}, 32'(hz1.idex_bubble), 32'd0);
    check_output({tag, "_issue"},       32'(hz1.issue),       32'd0);
    check_output({tag, "_fwd_a"},       32'(hz1.fwd_a),       32'd0);
    check_output({tag, "_fwd_b"},       32'(hz1.fwd_b),       32'd0);
    check_output({tag, "_stall_cnt"},   32'(hz1.stall_cnt),   32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    add_issue(ADDI_X2,    2'b00, 2'b00, 16'd0);
    add_issue(ADDI_X3_X2, 2'b01, 2'b00, 16'd0);
    add_idle(16'd0);
    add_idle(16'd0);
    add_issue(LW_X2,      2'b00, 2'b00, 16'd0);
    add_stall(ADDI_X3_X2, 16'd1);
    add_issue(ADDI_X3_X2, 2'b10, 2'b00, 16'd1);
    add_issue(ADDI_X2,    2'b00, 2'b00, 16'd1);
    add_issue(SW_X2,      2'b00, 2'b01, 16'd1);
    add_issue(ADDI_X3_X2, 2'b10, 2'b00, 16'd1);
    add_issue(NOP,        2'b00, 2'b00, 16'd1);
    add_issue(ADDI_X3_X0, 2'b00, 2'b00, 16'd1);
    add_idle(16'd1);
    add_idle(16'd1);
    add_issue(ADDI_X2,    2'b00, 2'b00, 16'd1);
    add_issue(ADDI_X2,    2'b00, 2'b00, 16'd1);
    add_issue(ADDI_X3_X2, 2'b01, 2'b00, 16'd1);
    add_idle(16'd1);
    add_idle(16'd1);
    add_issue(LW_X2,      2'b00, 2'b00, 16'd1);
    add_stall(SW_X2,      16'd2);
    add_issue(SW_X2,      2'b00, 2'b10, 16'd2);
    add_issue(LW_X2,      2'b00, 2'b00, 16'd2);
    add_issue(LUI_X5,     2'b00, 2'b00, 16'd2);
    add_idle(16'd2);
    add_idle(16'd2);
    add_issue(LW_X2,      2'b00, 2'b00, 16'd2);
    add_redir(1'b1, ADDI_X3_X2, 16'd2);
    add_issue(ADDI_X3_X2, 2'b10, 2'b00, 16'd2);
    add_redir(1'b0, NOP, 16'd2);
    add_idle(16'd2);
    add_idle(16'd2);
    add_issue(LW_X2,      2'b00, 2'b00, 16'd2);
    add_issue(UNK_OP,     2'b00, 2'b00, 16'd2);
    add_idle(16'd2);
    for (int k = 0; k < 4; k++) begin
      add_issue(LW_X2,      2'b00, 2'b00, 16'(2 + k));
      add_stall(ADDI_X3_X2, 16'(3 + k));
      add_issue(ADDI_X3_X2, 2'b10, 2'b00, 16'(3 + k));
    end

    reset = 1'b0;
    drive(1'b1, LW_X2, 1'b1);
    #1;
    check_all_zero("reset_init");
    @(negedge clk);
    drive(1'b0, NOP, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);
    check_output("sat_cnt_w2", 32'(hz3.stall_cnt), 32'd3);

    // Reset pulled low in the middle of a load-use stall.
    @(negedge clk);
    drive(1'b1, LW_X2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, ADDI_X3_X2, 1'b0);
    #1;
    check_output("rst_pre_stall", 32'(hz1.pc_stall), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    drive(1'b0, NOP, 1'b0);
    reset = 1'b1;
    begin
      vec_t v;
      v.valid = 1'b1; v.instr = ADDI_X3_X2; v.redir = 1'b0;
      v.exp_stall = 1'b0; v.exp_flush = 1'b0; v.exp_bubble = 1'b0; v.exp_issue = 1'b1;
      v.exp_fa = 2'b00; v.exp_fb = 2'b00; v.exp_cnt = 16'd0;
      apply_stimulus(v, 100);
    end

    // LOAD_LAT=2 instance: a dependent instruction waits two cycles.
    @(negedge clk);
    drive(1'b0, NOP, 1'b0);
    @(negedge clk);
    drive(1'b1, LW_X2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, ADDI_X3_X2, 1'b0);
    #1;
    check_output("lat2_stall1", 32'(hz2.pc_stall), 32'd1);
    @(posedge clk);
    #1;
    check_output("lat2_cnt1", 32'(hz2.stall_cnt), 32'd1);
    @(negedge clk);
    #1;
    check_output("lat2_stall2", 32'(hz2.pc_stall), 32'd1);
    check_output("lat2_noissue2", 32'(hz2.issue), 32'd0);
    @(posedge clk);
    #1;
    check_output("lat2_cnt2", 32'(hz2.stall_cnt), 32'd2);
    @(negedge clk);
    #1;
    check_output("lat2_release", 32'(hz2.pc_stall), 32'd0);
    check_output("lat2_issue", 32'(hz2.issue), 32'd1);
    @(posedge clk);
    #1;
    check_output("lat2_fwd_a", 32'(hz2.fwd_a), 32'd0);
    check_output("lat2_cnt_final", 32'(hz2.stall_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
